uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

UART transmitter, 8N1, LSB first, with an input FIFO and valid/ready byte interface. It is the transmit end of the serial link whose receive side takes 8N1 frames at 115200 baud on a 50 MHz clock. Upstream logic pushes bytes at clock rate; the block serialises them onto `tx` back-to-back while the FIFO holds data.

## Interface
- `CLK_DIV`, default 434: clock cycles per bit (50 MHz / 115200); legal range ≥ 2.
- `FIFO_DEPTH`, default 16: FIFO entries; power of two, ≥ 2.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  synchronous reset, active-high.
- `in_data`  input  8  byte to send.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  FIFO can accept; push occurs on an edge with `in_valid && in_ready`.
- `tx`  output  1  serial line, idle high; registered.
- `busy`  output  1  high when the state is not IDLE.
- `fifo_count`  output  $clog2(FIFO_DEPTH)+1  number of stored entries, 0..FIFO_DEPTH.

## Operation
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - `in_ready = (fifo_count != FIFO_DEPTH)`, combinational from the count only. It does not depend on a same-cycle pop.
  - Push only: count +1. Pop only: count −1. Push and pop on the same edge: count unchanged, both pointers advance.
- FSM states: IDLE, START, DATA, STOP.
  - **IDLE**: `tx`=1. If `fifo_count != 0`, pop the head into an 8-bit shift register, clear the baud counter, set `tx`=0, go to START.
  - **START**: hold for CLK_DIV cycles, then `tx`=shift[0], bit counter = 0, go to DATA.
  - **DATA**: each bit is held CLK_DIV cycles, then the register shifts right. After bit 7 completes, `tx`=1 and go to STOP.
  - **STOP**: hold for CLK_DIV cycles. At the end:
    - FIFO non-empty: pop, `tx`=0, go to START directly, with no idle gap.
    - FIFO empty: go to IDLE.
- Baud counter runs 0..CLK_DIV−1 and wraps at each bit boundary. Bit counter runs 0..7.
- Reset, including mid-frame:
  - Next edge: `tx`=1, state IDLE, `busy`=0, `fifo_count`=0, pointers 0, so `in_ready`=1.
  - The in-flight frame is truncated and FIFO contents are discarded.
  - A push presented on a reset edge is ignored.

## Timing
- Reset values: `tx`=1, `busy`=0, `in_ready`=1, `fifo_count`=0.
- Latency, byte pushed into an empty FIFO while IDLE:
  - Edge N: write; `fifo_count`=1.
  - Edge N+1: pop; `tx` falls, `busy` rises, `fifo_count`=0.
- Frame length is exactly 10·CLK_DIV cycles: start, 8 data, stop.
- Each bit level is stable for exactly CLK_DIV cycles.
- Consecutive queued bytes: the next start bit begins on the edge right after the previous stop bit's last cycle, so the period is 10·CLK_DIV.
- `busy` falls on the edge ending the last stop bit when the FIFO is empty.
- Continuous pushes from empty and idle, one per cycle:
  - After edge k ≥ 2, `fifo_count` = k−1.
  - FIFO is full after edge 17, so 17 bytes are accepted (1 in the shifter, 16 queued). `in_ready` is low from then on.
  - `in_ready` returns high the cycle after the next pop.

## Test plan
- Single byte, default parameters: push 0x41 ("A") → `tx` low for 434 cycles, then data bits 1,0,0,0,0,0,1,0 at 434 cycles each, then high. First falling edge occurs 1 cycle after the push edge; `busy` lasts 4340 cycles.
- Back-to-back stream, CLK_DIV=4: push "A".."Z" (26 bytes) whenever `in_ready` → decoded line equals 0x41..0x5A in order. No idle cycles between frames; total 26·40 cycles from the first start bit to `busy` falling.
- FIFO full, CLK_DIV=4, FIFO_DEPTH=16: hold `in_valid` with an incrementing byte for 20 cycles → exactly 17 bytes accepted. `in_ready`=0 with `fifo_count`=16 after edge 17. All 17 bytes transmitted in order; no loss or duplicates.
- Simultaneous push and pop, CLK_DIV=4: keep the FIFO at count 1 and push on the same edge the STOP→START pop occurs → `fifo_count` stays 1 and the byte order is preserved.
- Reset mid-frame: push 0x55, assert `rst` for 1 cycle during data bit 3 → `tx`=1, `busy`=0, `fifo_count`=0 on the next edge. A following push of 0x0F transmits a complete, correct frame.
- Minimum divider, CLK_DIV=2: push 0xFF then 0x00 → bits are 2 cycles wide and the frames are back-to-back and correct.

Source files
------------

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_tx_fifo : 8N1 LSB-first UART transmitter fed by a circular FIFO
// rev 1.0
// ------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;

  state_t        state, state_n;
  logic [7:0]    shift, shift_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [2:0]    bit_cnt, bit_n;
  logic          tx_n;
  logic          baud_end;

  assign in_ready   = (count != FULL);
  assign push       = in_valid && in_ready;
  assign fifo_count = count;
  assign busy       = (state != IDLE);
  assign baud_end   = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      tx       <= tx_n;
    end
  end

  // Popping at the end of STOP chains frames with no idle gap.
  always_comb begin
    state_n = state;
    shift_n = shift;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    tx_n    = tx;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (count != '0) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          baud_n  = '0;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_n  = '0;
          tx_n    = shift[0];
          bit_n   = 3'd0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_n = '0;
          if (bit_cnt == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            shift_n = {1'b0, shift[7:1]};
            tx_n    = shift[1];
            bit_n   = bit_cnt + 3'd1;
          end
        end else begin
          baud_n = baud_cnt + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_n = '0;
          if (count != '0) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_cnt + BW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// tb_uart_tx_fifo : scoreboard bench driving three transmitters (CLK_DIV 434, 4, 2)
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst       = 1'b1;
  logic       valid_drv = 1'b0;
  logic [7:0] in_data   = 8'h00;
  logic [1:0] active    = 2'd0;
  logic [2:0] in_valid, in_ready, tx, busy;
  logic [4:0] fifo_count [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DIV = (g == 0) ? 434 : ((g == 1) ? 4 : 2);
    uart_tx_fifo #(.CLK_DIV(DIV), .FIFO_DEPTH(16)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .tx         (tx[g]),
      .busy       (busy[g]),
      .fifo_count (fifo_count[g])
    );
  end

  assign in_valid = valid_drv ? (3'b001 << active) : 3'b000;

  logic       cur_tx, cur_ready, cur_busy;
  logic [4:0] cur_cnt;
  int         cur_div;
  assign cur_tx    = tx[active];
  assign cur_ready = in_ready[active];
  assign cur_busy  = busy[active];
  assign cur_cnt   = fifo_count[active];
  assign cur_div   = (active == 2'd0) ? 434 : ((active == 2'd1) ? 4 : 2);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] exp_q [$];
  int         first_start = -1;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Line level of a frame slot: 0 = start, 1..8 = data LSB first, 9 = stop.
  function automatic logic exp_level(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot-1];
  endfunction

  // Monitor: every cycle of a frame is compared with the expected line level.
  initial begin : monitor
    logic [7:0] exp_b, dec;
    bit         bad, abort, expected;
    int         div, slot;
    forever begin
      @(posedge clk); #2;
      if (!rst && cur_tx == 1'b0) begin
        div = cur_div;
        if (first_start < 0) first_start = cyc;
        expected = (exp_q.size() != 0);
        exp_b    = expected ? exp_q.pop_front() : 8'h00;
        bad = 1'b0; abort = 1'b0; dec = 8'h00;
        for (int i = 0; i < 10 * div; i++) begin
          if (i > 0) begin @(posedge clk); #2; end
          if (rst) begin abort = 1'b1; break; end
          slot = i / div;
          if (cur_tx !== exp_level(exp_b, slot)) bad = 1'b1;
          if ((i % div) == (div / 2) && slot >= 1 && slot <= 8) dec[slot-1] = cur_tx;
        end
        if (!abort) begin
          chk("frame_expected", int'(expected), 1);
          chk("frame_bits", {23'd0, bad, dec}, {24'd0, exp_b});
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_tx"},    int'(cur_tx),    1);
    chk({tag, "_busy"},  int'(cur_busy),  0);
    chk({tag, "_ready"}, int'(cur_ready), 1);
    chk({tag, "_count"}, int'(cur_cnt),   0);
  endtask

  task automatic do_reset(input logic [1:0] sel);
    valid_drv = 1'b0;
    active    = sel;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");
    first_start = -1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_data   = b;
    valid_drv = 1'b1;
    chk("push_ready", int'(cur_ready), 1);
    if (cur_ready) exp_q.push_back(b);
    @(negedge clk);
    valid_drv = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!cur_ready && n < budget) begin @(negedge clk); n++; end
    chk("ready_wait", int'(cur_ready), 1);
  endtask

  task automatic wait_idle(input int budget, output int fall_cyc);
    int n = 0;
    while (cur_busy && n < budget) begin @(negedge clk); n++; end
    chk("busy_falls", int'(cur_busy), 0);
    fall_cyc = cyc;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int         start, f, t0, acc;
    logic [7:0] base;

    repeat (3) @(negedge clk);
    do_reset(2'd0);

    // Single byte 'A' at the default divider: latency and frame length.
    push_byte(8'h41);
    chk("lat_count1", int'(cur_cnt), 1);
    chk("lat_tx_idle", int'(cur_tx), 1);
    chk("lat_busy0", int'(cur_busy), 0);
    @(negedge clk);
    chk("lat_tx_fall", int'(cur_tx), 0);
    chk("lat_busy1", int'(cur_busy), 1);
    chk("lat_count0", int'(cur_cnt), 0);
    start = cyc;
    wait_idle(5000, f);
    chk("frame_len_434", f - start, 4340);

    // Back-to-back 'A'..'Z' at CLK_DIV=4.
    do_reset(2'd1);
    for (int b = 0; b < 26; b++) begin
      wait_ready(200);
      push_byte(8'h41 + 8'(b));
    end
    wait_idle(2000, f);
    chk("stream_len", f - first_start, 26 * 40);
    chk("stream_drained", exp_q.size(), 0);

    // Randomized bytes and gaps.
    do_reset(2'd1);
    for (int b = 0; b < 25; b++) begin
      repeat ($urandom_range(0, 50)) @(negedge clk);
      wait_ready(200);
      push_byte(8'($urandom));
    end
    wait_idle(3000, f);

    // FIFO full: in_valid held 20 cycles from empty and idle.
    do_reset(2'd1);
    base = 8'($urandom);
    acc  = 0;
    t0   = cyc;
    for (int k = 1; k <= 20; k++) begin
      in_data   = base + 8'(k);
      valid_drv = 1'b1;
      if (cur_ready) begin exp_q.push_back(in_data); acc++; end
      @(negedge clk);
      if (k == 17) begin
        chk("full_count", int'(cur_cnt), 16);
        chk("full_ready", int'(cur_ready), 0);
      end
    end
    valid_drv = 1'b0;
    chk("full_accepted", acc, 17);
    while (cyc < t0 + 41) @(negedge clk);
    chk("full_ready_before_pop", int'(cur_ready), 0);
    @(negedge clk);
    chk("full_ready_after_pop", int'(cur_ready), 1);
    wait_idle(1000, f);
    chk("full_drained", exp_q.size(), 0);

    // Push on the same edge as each pop: count stays at one.
    do_reset(2'd1);
    push_byte(8'($urandom));
    start = cyc + 1;
    push_byte(8'($urandom));
    chk("simul_count_first", int'(cur_cnt), 1);
    for (int j = 1; j <= 4; j++) begin
      while (cyc < start + 40 * j - 1) @(negedge clk);
      push_byte(8'($urandom));
      chk("simul_count", int'(cur_cnt), 1);
    end
    wait_idle(400, f);

    // Reset during data bit 3; a push on the reset edge is dropped.
    do_reset(2'd1);
    push_byte(8'h55);
    start = cyc + 1;
    while (cyc < start + 17) @(negedge clk);
    rst       = 1'b1;
    in_data   = 8'hA7;
    valid_drv = 1'b1;
    @(negedge clk);
    check_reset_state("midreset");
    rst       = 1'b0;
    valid_drv = 1'b0;
    @(negedge clk);
    chk("midreset_push_dropped", int'(cur_cnt), 0);
    chk("midreset_still_idle", int'(cur_busy), 0);
    push_byte(8'h0F);
    @(negedge clk);
    start = cyc;
    wait_idle(200, f);
    chk("midreset_frame_len", f - start, 40);

    // Minimum divider: 0xFF then 0x00 back to back.
    do_reset(2'd2);
    push_byte(8'hFF);
    start = cyc + 1;
    push_byte(8'h00);
    wait_idle(200, f);
    chk("min_div_len", f - start, 40);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
